mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1: idle cycles between accepting a request and issuing it to memory; legal range 0..15.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid / ifu_req_ready  in / out  1 / 1  fetch request handshake.
REQ-005 ifu_req_wen, ifu_req_addr, ifu_req_wdata, ifu_req_wmask  in  1, 32, 32, 8  fetch request payload; wen is normally 0.
REQ-006 ifu_resp_valid / ifu_resp_ready  out / in  1 / 1  fetch response handshake.
REQ-007 ifu_resp_rdata  out  32  fetch read data.
REQ-008 lsu_* (req_valid, req_ready, req_wen, req_addr, req_wdata, req_wmask, resp_valid, resp_ready, resp_rdata): identical port set and widths to ifu_* for the load/store unit.
REQ-009 mem_valid  out  1  one-cycle strobe to the DPI memory controller.
REQ-010 mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask  out  1, 32, 32, 32, 8  memory command; mem_raddr = mem_waddr = latched address.
REQ-011 mem_rdata  in  32  combinational read data, valid in the cycle mem_valid=1.

Function
REQ-012 FSM states: IDLE, WAIT, ISSUE, RESP, held in a 2-bit register.
REQ-013 IDLE: arbitrate; assert req_ready only to the granted requester, and only when its req_valid=1.
REQ-014 Arbitration: single requester valid -> grant it; both valid -> grant the requester not granted last (round-robin).
REQ-015 Request accept (valid&&ready in IDLE): latch owner, wen, addr, wdata, wmask; load counter with LATENCY; next state WAIT if LATENCY>0, else ISSUE.
REQ-016 WAIT: decrement counter each cycle; go to ISSUE in the cycle the counter reaches 0, giving exactly LATENCY WAIT cycles.
REQ-017 ISSUE: mem_valid=1 for exactly one cycle, driven from latched fields; capture mem_rdata (read) or 0 (write) into a response register; next state RESP.
REQ-018 mem_valid=0 in all states other than ISSUE; mem_* payload outputs hold latched values (0 after reset).
REQ-019 RESP: assert resp_valid to the owner only, with rdata from the response register; stay in RESP until the owner's resp_ready=1, then go to IDLE.
REQ-020 Writes also produce a response (rdata=0) so that the LSU observes store completion.
REQ-021 At most one transaction is outstanding; req_ready=0 for both requesters outside IDLE.
REQ-022 Round-robin pointer updates only on request accept, never on a simple valid assertion.
REQ-023 Request latency from accept to resp_valid = LATENCY+2 cycles; the minimum turnaround from accept to the next accept is LATENCY+3 cycles.
REQ-024 Address and mask are passed through unmodified; alignment is the requester's responsibility.
REQ-025 A requester deasserting req_valid before accept is legal; no grant is recorded.

Reset
REQ-026 On reset assertion, the block immediately enters IDLE, clears the counter, sets the round-robin pointer so the IFU wins the first tie, and clears the latched fields and response register to 0.
REQ-027 During reset: all ready, resp_valid and mem_valid outputs are 0.
REQ-028 Reset mid-transaction (WAIT/ISSUE/RESP): the transaction is dropped with no mem_valid strobe and no response.

Structure
REQ-029 Shared package npc_mem_pkg holds the FSM state enum, the owner id enum (OWN_IFU, OWN_LSU), and the ADDR_W=32, DATA_W=32, MASK_W=8 constants.
REQ-030 Two-way round-robin grant logic is isolated in sub-module mem_rr_arb2 (inputs: two valids, pointer; output: grant id).

Verification
REQ-031 LATENCY=1, IFU read addr 0x80000000, memory returns 0x00000413 -> mem_valid pulses once, 2 cycles after accept; ifu_resp_rdata=0x00000413 in the next cycle.
REQ-032 IFU and LSU both valid in the same cycle after reset -> IFU granted first, LSU granted on its next IDLE; alternation holds across 4 back-to-back pairs.
REQ-033 LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> exactly one mem_valid with mem_wen=1 and matching payload; lsu_resp_rdata=0.
REQ-034 Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable; no new req_ready; acceptance resumes 1 cycle after resp_ready=1.
REQ-035 Assert reset during WAIT (LATENCY=4) -> no mem_valid and no resp_valid; after release, the IFU wins the first tie.
REQ-036 LATENCY=0 -> mem_valid in the cycle after accept, with resp_valid one cycle later.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared types and widths for the NPC memory arbiter.
package npc_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IFU/LSU) and memory-side signals of the arbiter.
interface mem_arbiter_if;
    import npc_mem_pkg::*;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic              ifu_req_wen;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic [DATA_W-1:0] ifu_req_wdata;
    logic [MASK_W-1:0] ifu_req_wmask;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_resp_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_req_wen;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_rdata;

    logic              mem_valid;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  ifu_req_valid, ifu_req_wen, ifu_req_addr, ifu_req_wdata, ifu_req_wmask, ifu_resp_ready,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    // Requesters plus memory controller view
    modport master (
        output ifu_req_valid, ifu_req_wen, ifu_req_addr, ifu_req_wdata, ifu_req_wmask, ifu_resp_ready,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
        output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        output mem_rdata
    );

endinterface

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin grant: ptr holds the requester granted last.
module mem_rr_arb2
    import npc_mem_pkg::*;
(
    input  logic   valid_ifu,
    input  logic   valid_lsu,
    input  owner_t ptr,
    output owner_t grant
);

    // Lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant = OWN_IFU;
        if (valid_ifu && valid_lsu) begin
            grant = (ptr == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (valid_lsu) begin
            grant = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding IFU/LSU arbiter in front of the DPI memory controller.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic [CNT_W-1:0]  cnt;
    mem_req_t          req_q;
    logic [DATA_W-1:0] resp_q;
    logic              mem_valid_q;
    logic              ifu_resp_valid_q;
    logic              lsu_resp_valid_q;

    owner_t            grant;
    logic              ifu_rdy;
    logic              lsu_rdy;
    logic              accept;
    logic              owner_resp_ready;
    mem_req_t          req_in;

    mem_rr_arb2 u_rr (
        .valid_ifu (bus.ifu_req_valid),
        .valid_lsu (bus.lsu_req_valid),
        .ptr       (last_grant),
        .grant     (grant)
    );

    // Ready only to the granted, valid requester while idle and out of reset
    assign ifu_rdy = !reset && (state == IDLE) && (grant == OWN_IFU) && bus.ifu_req_valid;
    assign lsu_rdy = !reset && (state == IDLE) && (grant == OWN_LSU) && bus.lsu_req_valid;
    assign accept  = ifu_rdy || lsu_rdy;

    assign req_in = (grant == OWN_IFU)
        ? '{wen: bus.ifu_req_wen, addr: bus.ifu_req_addr, wdata: bus.ifu_req_wdata, wmask: bus.ifu_req_wmask}
        : '{wen: bus.lsu_req_wen, addr: bus.lsu_req_addr, wdata: bus.lsu_req_wdata, wmask: bus.lsu_req_wmask};

    assign owner_resp_ready = (owner == OWN_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready;

    // Transaction FSM: accept -> LATENCY wait cycles -> one-cycle issue -> response hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= OWN_IFU;
            last_grant       <= OWN_LSU;
            cnt              <= '0;
            req_q            <= '0;
            resp_q           <= '0;
            mem_valid_q      <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        req_q      <= req_in;
                        cnt        <= LAT_CNT;
                        if (LATENCY == 0) begin
                            state       <= ISSUE;
                            mem_valid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= ISSUE;
                        mem_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    mem_valid_q      <= 1'b0;
                    resp_q           <= req_q.wen ? '0 : bus.mem_rdata;
                    ifu_resp_valid_q <= (owner == OWN_IFU);
                    lsu_resp_valid_q <= (owner == OWN_LSU);
                    state            <= RESP;
                end
                RESP: begin
                    if (owner_resp_ready) begin
                        ifu_resp_valid_q <= 1'b0;
                        lsu_resp_valid_q <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ifu_req_ready  = ifu_rdy;
    assign bus.lsu_req_ready  = lsu_rdy;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.ifu_resp_rdata = resp_q;
    assign bus.lsu_resp_rdata = resp_q;

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_wen   = req_q.wen;
    assign bus.mem_raddr = req_q.addr;
    assign bus.mem_waddr = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_wmask = req_q.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at LATENCY 1 (main), 4 (reset in WAIT) and 0.
module tb_mem_arbiter;
    import npc_mem_pkg::*;

    // Memory model: read data is the address XOR this constant
    localparam logic [31:0] MEMX = 32'h8000_0413;

    typedef struct packed {
        owner_t      o;
        logic [31:0] d;
    } resp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   b_bad = 0;
    logic b_win = 1'b0;

    mem_req_t exp_mem[$];
    resp_t    exp_resp[$];
    mem_req_t em;
    resp_t    er;

    mem_arbiter_if a();
    mem_arbiter_if b();
    mem_arbiter_if c();

    mem_arbiter #(.LATENCY(1)) dut_a (.clock(clock), .reset(rst),   .bus(a));
    mem_arbiter #(.LATENCY(4)) dut_b (.clock(clock), .reset(rst_b), .bus(b));
    mem_arbiter #(.LATENCY(0)) dut_c (.clock(clock), .reset(rst),   .bus(c));

    assign a.mem_rdata = a.mem_valid ? (a.mem_raddr ^ MEMX) : 32'hBAD0_0000;
    assign b.mem_rdata = b.mem_valid ? (b.mem_raddr ^ MEMX) : 32'hBAD0_0000;
    assign c.mem_rdata = c.mem_valid ? (c.mem_raddr ^ MEMX) : 32'hBAD0_0000;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic mem_req_t ifu_pl(input int k);
        mem_req_t p;
        p.wen   = 1'b0;
        p.addr  = 32'h8000_0000 + 32'(16 * k);
        p.wdata = 32'h0;
        p.wmask = 8'h0F;
        return p;
    endfunction

    function automatic mem_req_t lsu_pl(input int k);
        mem_req_t p;
        p.wen   = (k % 2 == 1);
        p.addr  = 32'h8000_3000 + 32'(8 * k);
        p.wdata = 32'h0000_1000 + 32'(k);
        p.wmask = 8'hFF;
        return p;
    endfunction

    task automatic push(input owner_t o, input mem_req_t p);
        resp_t r;
        r.o = o;
        r.d = p.wen ? 32'h0 : (p.addr ^ MEMX);
        exp_mem.push_back(p);
        exp_resp.push_back(r);
    endtask

    task automatic drive(input owner_t o, input mem_req_t p);
        if (o == OWN_IFU) {a.ifu_req_wen, a.ifu_req_addr, a.ifu_req_wdata, a.ifu_req_wmask} = p;
        else              {a.lsu_req_wen, a.lsu_req_addr, a.lsu_req_wdata, a.lsu_req_wmask} = p;
    endtask

    // Present one request on DUT a, wait for accept, queue the expectation
    task automatic send(input owner_t o, input mem_req_t p);
        int   g;
        logic rdy;
        g = 0;
        drive(o, p);
        if (o == OWN_IFU) a.ifu_req_valid = 1'b1; else a.lsu_req_valid = 1'b1;
        do begin
            @(negedge clock);
            g++;
            rdy = (o == OWN_IFU) ? a.ifu_req_ready : a.lsu_req_ready;
        end while (!rdy && g < 50);
        chk("send_accept", 32'(rdy), 32'(1));
        if (rdy) push(o, p);
        @(posedge clock); #1;
        a.ifu_req_valid = 1'b0;
        a.lsu_req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_resp.size() != 0 && g < 50) begin
            @(negedge clock);
            g++;
        end
        chk("drain_pending", 32'(exp_resp.size()), 32'(0));
        @(posedge clock); #1;
    endtask

    // Monitor for DUT a: memory strobes and response handshakes against the queues
    always @(negedge clock) begin
        if (a.mem_valid) begin
            chk("mem_strobe_expected", 32'(exp_mem.size() != 0), 32'(1));
            if (exp_mem.size() != 0) begin
                em = exp_mem.pop_front();
                chk("mem_wen",   32'(a.mem_wen), 32'(em.wen));
                chk("mem_raddr", a.mem_raddr, em.addr);
                chk("mem_waddr", a.mem_waddr, em.addr);
                chk("mem_wdata", a.mem_wdata, em.wdata);
                chk("mem_wmask", 32'(a.mem_wmask), 32'(em.wmask));
            end
        end
        if (a.ifu_resp_valid && a.lsu_resp_valid) chk("resp_both_valid", 32'(1), 32'(0));
        if ((a.ifu_resp_valid && a.ifu_resp_ready) || (a.lsu_resp_valid && a.lsu_resp_ready)) begin
            chk("resp_expected", 32'(exp_resp.size() != 0), 32'(1));
            if (exp_resp.size() != 0) begin
                er = exp_resp.pop_front();
                if (a.ifu_resp_valid) begin
                    chk("resp_owner",     32'(OWN_IFU), 32'(er.o));
                    chk("ifu_resp_rdata", a.ifu_resp_rdata, er.d);
                end else begin
                    chk("resp_owner",     32'(OWN_LSU), 32'(er.o));
                    chk("lsu_resp_rdata", a.lsu_resp_rdata, er.d);
                end
            end
        end
    end

    // DUT b must stay silent while a reset-dropped transaction would have completed
    always @(negedge clock) begin
        if (b_win && (b.mem_valid || b.ifu_resp_valid || b.lsu_resp_valid)) b_bad <= b_bad + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, g, ki, kl, last_acc;
        mem_req_t p;

        {a.ifu_req_wen, a.ifu_req_addr, a.ifu_req_wdata, a.ifu_req_wmask} = '0;
        {a.lsu_req_wen, a.lsu_req_addr, a.lsu_req_wdata, a.lsu_req_wmask} = '0;
        {b.ifu_req_wen, b.ifu_req_addr, b.ifu_req_wdata, b.ifu_req_wmask} = '0;
        {b.lsu_req_wen, b.lsu_req_addr, b.lsu_req_wdata, b.lsu_req_wmask} = '0;
        {c.ifu_req_wen, c.ifu_req_addr, c.ifu_req_wdata, c.ifu_req_wmask} = '0;
        {c.lsu_req_wen, c.lsu_req_addr, c.lsu_req_wdata, c.lsu_req_wmask} = '0;
        b.ifu_req_valid = 1'b0; b.lsu_req_valid = 1'b0;
        c.ifu_req_valid = 1'b0; c.lsu_req_valid = 1'b0;
        a.ifu_resp_ready = 1'b1; a.lsu_resp_ready = 1'b1;
        b.ifu_resp_ready = 1'b1; b.lsu_resp_ready = 1'b1;
        c.ifu_resp_ready = 1'b1; c.lsu_resp_ready = 1'b1;

        // Requests raised during reset must see no ready
        a.ifu_req_valid = 1'b1;
        a.lsu_req_valid = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ifu_ready",  32'(a.ifu_req_ready),  32'(0));
        chk("rst_lsu_ready",  32'(a.lsu_req_ready),  32'(0));
        chk("rst_mem_valid",  32'(a.mem_valid),      32'(0));
        chk("rst_ifu_rvalid", 32'(a.ifu_resp_valid), 32'(0));
        chk("rst_lsu_rvalid", 32'(a.lsu_resp_valid), 32'(0));
        chk("rst_mem_raddr",  a.mem_raddr, 32'h0);
        chk("rst_mem_wdata",  a.mem_wdata, 32'h0);
        @(posedge clock); #1;
        a.ifu_req_valid = 1'b0;
        a.lsu_req_valid = 1'b0;
        rst   = 1'b0;
        rst_b = 1'b0;

        // Both requesters continuously valid: IFU first, then strict alternation
        ki = 0; kl = 0; acc = 0; g = 0; last_acc = 0;
        drive(OWN_IFU, ifu_pl(ki));
        drive(OWN_LSU, lsu_pl(kl));
        a.ifu_req_valid = 1'b1;
        a.lsu_req_valid = 1'b1;
        while (acc < 8 && g < 100) begin
            @(negedge clock);
            g++;
            if (a.ifu_req_ready || a.lsu_req_ready) begin
                chk("tie_both_ready", 32'(a.ifu_req_ready && a.lsu_req_ready), 32'(0));
                if (acc > 0) chk("tie_turnaround", 32'(cyc - last_acc), 32'(4));
                last_acc = cyc;
                if (acc % 2 == 0) begin
                    chk("tie_grant_ifu", 32'(a.ifu_req_ready), 32'(1));
                    push(OWN_IFU, ifu_pl(ki));
                end else begin
                    chk("tie_grant_lsu", 32'(a.lsu_req_ready), 32'(1));
                    push(OWN_LSU, lsu_pl(kl));
                end
                @(posedge clock); #1;
                if (acc % 2 == 0) begin ki++; drive(OWN_IFU, ifu_pl(ki)); end
                else              begin kl++; drive(OWN_LSU, lsu_pl(kl)); end
                acc++;
            end
        end
        a.ifu_req_valid = 1'b0;
        a.lsu_req_valid = 1'b0;
        chk("tie_accepts", 32'(acc), 32'(8));
        drain();

        // IFU read at LATENCY 1: strobe two cycles after accept, response the next
        p = '{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h0F};
        send(OWN_IFU, p);
        @(negedge clock);
        chk("r31_wait_no_strobe", 32'(a.mem_valid), 32'(0));
        @(negedge clock);
        chk("r31_strobe", 32'(a.mem_valid), 32'(1));
        @(negedge clock);
        chk("r31_strobe_once", 32'(a.mem_valid),      32'(0));
        chk("r31_resp_valid",  32'(a.ifu_resp_valid), 32'(1));
        chk("r31_rdata",       a.ifu_resp_rdata, 32'h0000_0413);
        drain();

        // LSU store: one strobe with full payload, zero response data
        p = '{wen: 1'b1, addr: 32'h8000_1000, wdata: 32'hDEAD_BEEF, wmask: 8'h0F};
        send(OWN_LSU, p);
        drain();

        // Response backpressure: stable response, no new grant, resume one cycle after ready
        a.ifu_resp_ready = 1'b0;
        p = '{wen: 1'b0, addr: 32'h8000_0040, wdata: 32'h0, wmask: 8'hFF};
        send(OWN_IFU, p);
        p = '{wen: 1'b0, addr: 32'h8000_0080, wdata: 32'h0, wmask: 8'h03};
        drive(OWN_LSU, p);
        a.lsu_req_valid = 1'b1;
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!a.ifu_resp_valid && g < 20);
        for (int i = 0; i < 5; i++) begin
            chk("r34_hold_valid", 32'(a.ifu_resp_valid), 32'(1));
            chk("r34_hold_rdata", a.ifu_resp_rdata, 32'h0000_0453);
            chk("r34_no_ready",   32'(a.ifu_req_ready || a.lsu_req_ready), 32'(0));
            @(negedge clock);
        end
        @(posedge clock); #1;
        a.ifu_resp_ready = 1'b1;
        @(negedge clock);
        chk("r34_still_busy", 32'(a.lsu_req_ready), 32'(0));
        @(posedge clock); #1;
        @(negedge clock);
        chk("r34_resume", 32'(a.lsu_req_ready), 32'(1));
        if (a.lsu_req_ready) push(OWN_LSU, p);
        @(posedge clock); #1;
        a.lsu_req_valid = 1'b0;
        drain();

        // LATENCY 4: reset in WAIT drops the transaction; pointer returns to IFU
        b.ifu_req_addr  = 32'h8000_0200;
        b.ifu_req_valid = 1'b1;
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!b.ifu_req_ready && g < 20);
        chk("b_accept", 32'(b.ifu_req_ready), 32'(1));
        @(posedge clock); #1;
        b.ifu_req_valid = 1'b0;
        b_win = 1'b1;
        @(posedge clock); #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        rst_b = 1'b0;
        repeat (8) @(negedge clock);
        b_win = 1'b0;
        chk("b_dropped_silent", 32'(b_bad), 32'(0));
        @(posedge clock); #1;
        b.ifu_req_valid = 1'b1;
        b.lsu_req_valid = 1'b1;
        @(negedge clock);
        chk("b_tie_ifu", 32'(b.ifu_req_ready), 32'(1));
        chk("b_tie_lsu", 32'(b.lsu_req_ready), 32'(0));
        @(posedge clock); #1;
        b.ifu_req_valid = 1'b0;
        b.lsu_req_valid = 1'b0;

        // LATENCY 0: strobe right after accept, response one cycle later
        c.ifu_req_addr  = 32'h8000_0100;
        c.ifu_req_valid = 1'b1;
        @(negedge clock);
        chk("c_accept", 32'(c.ifu_req_ready), 32'(1));
        @(posedge clock); #1;
        c.ifu_req_valid = 1'b0;
        @(negedge clock);
        chk("c_strobe",      32'(c.mem_valid), 32'(1));
        chk("c_strobe_addr", c.mem_raddr, 32'h8000_0100);
        chk("c_early_resp",  32'(c.ifu_resp_valid), 32'(0));
        @(negedge clock);
        chk("c_strobe_once", 32'(c.mem_valid),      32'(0));
        chk("c_resp_valid",  32'(c.ifu_resp_valid), 32'(1));
        chk("c_rdata",       c.ifu_resp_rdata, 32'h0000_0513);

        repeat (4) @(negedge clock);
        chk("end_mem_queue",  32'(exp_mem.size()),  32'(0));
        chk("end_resp_queue", 32'(exp_resp.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
